// File: rtl/mem_arb_pkg.sv
// Shared types for the SRAM port arbiter: requester ids carried in the read
// tag pipeline and the ownership states of the arbiter FSM.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    REQ_IF = 2'd0,
    REQ_D  = 2'd1,
    REQ_P  = 2'd2
  } req_id_e;

  typedef enum logic [1:0] {
    NORMAL  = 2'd0,
    DRAIN   = 2'd1,
    PROG    = 2'd2,
    RELEASE = 2'd3
  } arb_state_e;

endpackage

// File: rtl/mem_arb_rr2.sv
// Two-requester round-robin grant; the pointer moves only when a grant is issued.
// Latency: grant is combinational from req/en in the same cycle.
// Backpressure: an ungranted requester waits at most one granted cycle of the other.
module mem_arb_rr2 (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a,
  output logic gnt_b
);

  // prio_b_q=1 means requester b wins a tie; reset and clr favour a.
  logic prio_b_q;
  logic prio_b_d;

  // Tie-break on the pointer, then advance it past whoever was granted.
  always_comb begin
    gnt_a    = en && req_a && (!req_b || !prio_b_q);
    gnt_b    = en && req_b && (!req_a ||  prio_b_q);
    prio_b_d = prio_b_q;
    if (clr) begin
      prio_b_d = 1'b0;
    end else if (gnt_a) begin
      prio_b_d = 1'b1;
    end else if (gnt_b) begin
      prio_b_d = 1'b0;
    end
  end

  // Pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_b_q <= 1'b0;
    end else begin
      prio_b_q <= prio_b_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port SRAM between CPU fetch, CPU data and the JTAG programmer.
// Latency: gnt in cycle N, mem_* driven in N+1, tagged rvalid with mem_rdata in N+2.
// Backpressure: requesters hold req until gnt; programming mode drains and holds the CPU.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      prog_mode,
  input  logic                      if_req,
  input  logic [ADDR_WIDTH-1:0]     if_addr,
  output logic                      if_gnt,
  output logic                      if_rvalid,
  output logic [DATA_WIDTH-1:0]     if_rdata,
  input  logic                      d_req,
  input  logic                      d_we,
  input  logic [DATA_WIDTH/8-1:0]   d_be,
  input  logic [ADDR_WIDTH-1:0]     d_addr,
  input  logic [DATA_WIDTH-1:0]     d_wdata,
  output logic                      d_gnt,
  output logic                      d_rvalid,
  output logic [DATA_WIDTH-1:0]     d_rdata,
  input  logic                      p_req,
  input  logic                      p_we,
  input  logic [ADDR_WIDTH-1:0]     p_addr,
  input  logic [DATA_WIDTH-1:0]     p_wdata,
  output logic                      p_gnt,
  output logic                      p_rvalid,
  output logic [DATA_WIDTH-1:0]     p_rdata,
  output logic                      mem_en,
  output logic [DATA_WIDTH/8-1:0]   mem_we,
  output logic [ADDR_WIDTH-1:0]     mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  input  logic [DATA_WIDTH-1:0]     mem_rdata,
  output logic                      cpu_hold
);

  localparam int NBYTES = DATA_WIDTH / 8;

  arb_state_e state_q, state_d;

  // Memory stage: the request accepted last cycle, presented to the SRAM.
  logic                  mem_en_q, mem_en_d;
  logic [NBYTES-1:0]     mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

  // Read tag pipeline: s1 rides with the memory stage, s2 with the returned data.
  logic    s1_rd_q, s1_rd_d;
  req_id_e s1_id_q, s1_id_d;
  logic    s2_vld_q, s2_vld_d;
  req_id_e s2_id_q, s2_id_d;

  logic cpu_en;
  logic p_en;
  logic rr_clr;
  logic pipe_empty;

  assign pipe_empty = !mem_en_q && !s1_rd_q && !s2_vld_q;

  // Ownership FSM: who may be granted this cycle and when ownership moves.
  always_comb begin
    state_d = state_q;
    cpu_en  = 1'b0;
    p_en    = 1'b0;
    rr_clr  = 1'b0;
    case (state_q)
      NORMAL: begin
        if (prog_mode) state_d = DRAIN;
        else           cpu_en  = 1'b1;
      end
      DRAIN: begin
        if (pipe_empty) state_d = prog_mode ? PROG : RELEASE;
      end
      PROG: begin
        if (!prog_mode) state_d = RELEASE;
        else            p_en    = 1'b1;
      end
      RELEASE: begin
        if (pipe_empty) begin
          state_d = NORMAL;
          rr_clr  = 1'b1;
        end
      end
      default: state_d = NORMAL;
    endcase
    cpu_hold = (state_q != NORMAL) || prog_mode;
  end

  // Grants are suppressed while reset is asserted so no handshake completes into a
  // pipeline that is being cleared.
  mem_arb_rr2 u_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (cpu_en && rst_n),
    .clr   (rr_clr),
    .req_a (if_req),
    .req_b (d_req),
    .gnt_a (if_gnt),
    .gnt_b (d_gnt)
  );

  assign p_gnt = p_en && p_req && rst_n;

  // Build the next memory-stage access and read tag from whichever port was granted.
  // A data write with no byte enables is accepted but never touches the SRAM.
  always_comb begin
    mem_en_d    = 1'b0;
    mem_we_d    = '0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    s1_rd_d     = 1'b0;
    s1_id_d     = REQ_IF;
    if (if_gnt) begin
      mem_en_d   = 1'b1;
      mem_addr_d = if_addr;
      s1_rd_d    = 1'b1;
      s1_id_d    = REQ_IF;
    end else if (d_gnt) begin
      mem_addr_d = d_addr;
      if (d_we) begin
        mem_en_d    = |d_be;
        mem_we_d    = d_be;
        mem_wdata_d = d_wdata;
      end else begin
        mem_en_d = 1'b1;
        s1_rd_d  = 1'b1;
        s1_id_d  = REQ_D;
      end
    end else if (p_gnt) begin
      mem_en_d   = 1'b1;
      mem_addr_d = p_addr;
      if (p_we) begin
        mem_we_d    = '1;
        mem_wdata_d = p_wdata;
      end else begin
        s1_rd_d = 1'b1;
        s1_id_d = REQ_P;
      end
    end
    s2_vld_d = s1_rd_q;
    s2_id_d  = s1_id_q;
  end

  // State, memory stage and tag pipeline registers; reset discards in-flight reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= NORMAL;
      mem_en_q    <= 1'b0;
      mem_we_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      s1_rd_q     <= 1'b0;
      s1_id_q     <= REQ_IF;
      s2_vld_q    <= 1'b0;
      s2_id_q     <= REQ_IF;
    end else begin
      state_q     <= state_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      s1_rd_q     <= s1_rd_d;
      s1_id_q     <= s1_id_d;
      s2_vld_q    <= s2_vld_d;
      s2_id_q     <= s2_id_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  // The SRAM output register is shared by all ports; rvalid says whose it is.
  assign if_rvalid = s2_vld_q && (s2_id_q == REQ_IF);
  assign d_rvalid  = s2_vld_q && (s2_id_q == REQ_D);
  assign p_rvalid  = s2_vld_q && (s2_id_q == REQ_P);
  assign if_rdata  = mem_rdata;
  assign d_rdata   = mem_rdata;
  assign p_rdata   = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: SRAM model, reference-memory scoreboard,
// vector table for arbitration, directed corner sequences and random traffic.
module tb_mem_port_arbiter;

  localparam int AW = 6;
  localparam int DW = 32;
  localparam int NB = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          prog_mode = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_gnt, if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          d_req = 1'b0, d_we = 1'b0;
  logic [NB-1:0] d_be = '0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          d_gnt, d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          p_req = 1'b0, p_we = 1'b0;
  logic [AW-1:0] p_addr = '0;
  logic [DW-1:0] p_wdata = '0;
  logic          p_gnt, p_rvalid;
  logic [DW-1:0] p_rdata;
  logic          mem_en;
  logic [NB-1:0] mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          cpu_hold;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .prog_mode(prog_mode),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
    .p_gnt(p_gnt), .p_rvalid(p_rvalid), .p_rdata(p_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .cpu_hold(cpu_hold)
  );

  function automatic logic [DW-1:0] init_word(input int i);
    if (i == 5) return 32'h1122_3344;
    return DW'(i * 3);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // Synchronous SRAM: data read at an enabled edge appears for the following cycle.
  logic [DW-1:0] sram [64];
  initial begin
    for (int i = 0; i < 64; i++) sram[i] = init_word(i);
    forever begin
      @(posedge clk);
      if (mem_en) begin
        if (mem_we == '0) mem_rdata <= sram[mem_addr];
        else for (int b = 0; b < NB; b++)
          if (mem_we[b]) sram[mem_addr][b*8 +: 8] = mem_wdata[b*8 +: 8];
      end
    end
  end

  // Scoreboard: accesses take effect in grant order on a reference memory; each
  // grant must show up on mem_* one cycle later and a read must return two cycles later.
  typedef struct packed {logic vld; logic [1:0] id; logic [DW-1:0] data;} rd_ev_t;
  typedef struct packed {logic en; logic [NB-1:0] we; logic [AW-1:0] addr; logic [DW-1:0] wdata;} acc_t;
  logic [DW-1:0] ref_mem [64];
  rd_ev_t rdq[$];
  rd_ev_t cur, ev;
  acc_t   exp_acc, nxt;

  initial begin
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
    exp_acc = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rdq.delete();
        exp_acc = '0;
        chk("rst_outs", {if_gnt, d_gnt, p_gnt, if_rvalid, d_rvalid, p_rvalid, mem_en}, 0);
      end else begin
        chk("one_gnt", ((int'(if_gnt) + int'(d_gnt) + int'(p_gnt)) <= 1), 1);
        chk("mem_en", mem_en, exp_acc.en);
        chk("mem_we", mem_we, exp_acc.we);
        if (exp_acc.en) chk("mem_addr", mem_addr, exp_acc.addr);
        if (exp_acc.en && exp_acc.we != 0) chk("mem_wdata", mem_wdata, exp_acc.wdata);
        cur = '0;
        nxt = '0;
        if (if_gnt) begin
          nxt.en = 1'b1; nxt.addr = if_addr;
          cur = '{vld: 1'b1, id: 2'd0, data: ref_mem[if_addr]};
        end else if (d_gnt) begin
          if (d_we) begin
            if (d_be != 0) begin
              nxt = '{en: 1'b1, we: d_be, addr: d_addr, wdata: d_wdata};
              for (int b = 0; b < NB; b++)
                if (d_be[b]) ref_mem[d_addr][b*8 +: 8] = d_wdata[b*8 +: 8];
            end
          end else begin
            nxt.en = 1'b1; nxt.addr = d_addr;
            cur = '{vld: 1'b1, id: 2'd1, data: ref_mem[d_addr]};
          end
        end else if (p_gnt) begin
          if (p_we) begin
            nxt = '{en: 1'b1, we: '1, addr: p_addr, wdata: p_wdata};
            ref_mem[p_addr] = p_wdata;
          end else begin
            nxt.en = 1'b1; nxt.addr = p_addr;
            cur = '{vld: 1'b1, id: 2'd2, data: ref_mem[p_addr]};
          end
        end
        exp_acc = nxt;
        rdq.push_back(cur);
        if (rdq.size() > 2) ev = rdq.pop_front();
        else ev = '0;
        chk("if_rvalid", if_rvalid, ev.vld && ev.id == 2'd0);
        chk("d_rvalid",  d_rvalid,  ev.vld && ev.id == 2'd1);
        chk("p_rvalid",  p_rvalid,  ev.vld && ev.id == 2'd2);
        if (ev.vld) begin
          case (ev.id)
            2'd0:    chk("if_rdata", if_rdata, ev.data);
            2'd1:    chk("d_rdata",  d_rdata,  ev.data);
            default: chk("p_rdata",  p_rdata,  ev.data);
          endcase
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      cyc();
      if_req = 1'b0; d_req = 1'b0; p_req = 1'b0;
    end
  endtask

  task automatic do_reset();
    cyc();
    rst_n = 1'b0; if_req = 1'b0; d_req = 1'b0; p_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  typedef struct {
    logic ir; logic [AW-1:0] ia;
    logic dr; logic dwe; logic [NB-1:0] be; logic [AW-1:0] da;
    logic ei; logic ed; logic een; logic [NB-1:0] ewe;
  } vec_t;

  function automatic vec_t mk(logic ir, logic [AW-1:0] ia, logic dr, logic dwe, logic [NB-1:0] be,
                              logic [AW-1:0] da, logic ei, logic ed, logic een, logic [NB-1:0] ewe);
    vec_t v;
    v = '{ir, ia, dr, dwe, be, da, ei, ed, een, ewe};
    return v;
  endfunction

  vec_t tbl [16];
  logic ig, dg;
  int   iw, dw;

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    // Arbitration vectors, applied on consecutive cycles from a fresh reset.
    tbl[0]  = mk(1, 1,  1, 0, 4'h0, 2,  1, 0, 1, 4'h0);
    tbl[1]  = mk(1, 3,  1, 0, 4'h0, 2,  0, 1, 1, 4'h0);
    tbl[2]  = mk(1, 3,  1, 1, 4'h3, 4,  1, 0, 1, 4'h0);
    tbl[3]  = mk(0, 0,  1, 1, 4'h3, 4,  0, 1, 1, 4'h3);
    tbl[4]  = mk(0, 0,  1, 1, 4'h0, 5,  0, 1, 0, 4'h0);
    tbl[5]  = mk(0, 0,  0, 0, 4'h0, 0,  0, 0, 0, 4'h0);
    tbl[6]  = mk(1, 6,  1, 0, 4'h0, 7,  1, 0, 1, 4'h0);
    tbl[7]  = mk(0, 0,  1, 0, 4'h0, 7,  0, 1, 1, 4'h0);
    tbl[8]  = mk(0, 0,  0, 0, 4'h0, 0,  0, 0, 0, 4'h0);
    tbl[9]  = mk(1, 8,  1, 0, 4'h0, 9,  1, 0, 1, 4'h0);
    tbl[10] = mk(1, 10, 1, 0, 4'h0, 9,  0, 1, 1, 4'h0);
    tbl[11] = mk(1, 10, 0, 0, 4'h0, 0,  1, 0, 1, 4'h0);
    tbl[12] = mk(1, 11, 1, 1, 4'hF, 12, 0, 1, 1, 4'hF);
    tbl[13] = mk(1, 11, 0, 0, 4'h0, 0,  1, 0, 1, 4'h0);
    tbl[14] = mk(1, 13, 0, 0, 4'h0, 0,  1, 0, 1, 4'h0);
    tbl[15] = mk(0, 0,  0, 0, 4'h0, 0,  0, 0, 0, 4'h0);

    // Reset state.
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_if_gnt", if_gnt, 0);
    chk("rst_d_gnt", d_gnt, 0);
    chk("rst_p_gnt", p_gnt, 0);
    chk("rst_rvalid", {if_rvalid, d_rvalid, p_rvalid}, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_cpu_hold", cpu_hold, 0);

    // Both CPU ports requesting: alternate starting with IF; then DATA alone every cycle.
    if_addr = 1; d_addr = 2; d_we = 1'b0;
    for (int k = 0; k < 9; k++) begin
      cyc();
      if_req = (k < 6); d_req = 1'b1;
      @(negedge clk);
      chk("rr_if_gnt", if_gnt, (k < 6) && (k % 2 == 0));
      chk("rr_d_gnt", d_gnt, !((k < 6) && (k % 2 == 0)));
    end
    idle(3);

    // Back-to-back fetches at 0,1,2.
    for (int k = 0; k < 5; k++) begin
      cyc();
      if_req = (k < 3); if_addr = AW'(k);
      @(negedge clk);
      chk("b2b_if_gnt", if_gnt, k < 3);
      chk("b2b_if_rvalid", if_rvalid, k >= 2);
      if (k >= 2) chk("b2b_if_rdata", if_rdata, (k - 2) * 3);
    end
    idle(3);

    // Partial write then read-back; zero byte-enable write is a no-op.
    cyc(); d_req = 1; d_we = 1; d_be = 4'b0011; d_addr = 5; d_wdata = 32'hAABB_CCDD;
    @(negedge clk); chk("bw_gnt", d_gnt, 1);
    cyc(); d_we = 0; d_be = 0;
    @(negedge clk); chk("rd5_gnt", d_gnt, 1); chk("bw_mem_en", mem_en, 1);
    chk("bw_mem_we", mem_we, 4'b0011); chk("bw_mem_addr", mem_addr, 5);
    cyc(); d_req = 0;
    @(negedge clk); chk("rd5_mem_we", mem_we, 0); chk("bw_no_rvalid", d_rvalid, 0);
    cyc(); d_req = 1; d_we = 1; d_be = 0; d_addr = 6; d_wdata = 32'hFFFF_FFFF;
    @(negedge clk); chk("be0_gnt", d_gnt, 1); chk("rd5_rvalid", d_rvalid, 1);
    chk("rd5_rdata", d_rdata, 32'h1122_CCDD);
    cyc(); d_req = 0; d_we = 0;
    @(negedge clk); chk("be0_mem_en", mem_en, 0); chk("be0_no_rvalid", d_rvalid, 0);
    idle(3);

    // Vector table from a fresh round-robin pointer.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      cyc();
      if_req = tbl[i].ir; if_addr = tbl[i].ia;
      d_req = tbl[i].dr; d_we = tbl[i].dwe; d_be = tbl[i].be; d_addr = tbl[i].da;
      d_wdata = 32'hA5A5_0000 | DW'(tbl[i].da);
      @(negedge clk);
      chk($sformatf("tbl%0d_if_gnt", i), if_gnt, tbl[i].ei);
      chk($sformatf("tbl%0d_d_gnt", i), d_gnt, tbl[i].ed);
      if (i > 0) begin
        chk($sformatf("tbl%0d_mem_en", i - 1), mem_en, tbl[i-1].een);
        chk($sformatf("tbl%0d_mem_we", i - 1), mem_we, tbl[i-1].ewe);
      end
    end
    idle(3);

    // Enter programming mode behind an in-flight fetch, program, read back, leave.
    cyc(); if_req = 1; if_addr = 20;
    @(negedge clk); chk("pg_c0_if_gnt", if_gnt, 1);
    cyc(); prog_mode = 1; if_addr = 21; p_req = 1; p_we = 1; p_addr = 3; p_wdata = 32'hDEAD_BEEF;
    @(negedge clk); chk("pg_c1_if_gnt", if_gnt, 0); chk("pg_c1_hold", cpu_hold, 1); chk("pg_c1_p_gnt", p_gnt, 0);
    cyc();
    @(negedge clk); chk("pg_c2_if_gnt", if_gnt, 0); chk("pg_c2_p_gnt", p_gnt, 0); chk("pg_c2_hold", cpu_hold, 1);
    chk("pg_c2_if_rvalid", if_rvalid, 1); chk("pg_c2_if_rdata", if_rdata, 60);
    cyc();
    @(negedge clk); chk("pg_c3_p_gnt", p_gnt, 0); chk("pg_c3_hold", cpu_hold, 1);
    cyc();
    @(negedge clk); chk("pg_c4_p_gnt", p_gnt, 1); chk("pg_c4_if_gnt", if_gnt, 0);
    cyc(); p_we = 0;
    @(negedge clk); chk("pg_c5_p_gnt", p_gnt, 1); chk("pg_c5_mem_we", mem_we, 4'hF);
    chk("pg_c5_mem_addr", mem_addr, 3); chk("pg_c5_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    cyc(); p_req = 0;
    @(negedge clk); chk("pg_c6_mem_en", mem_en, 1); chk("pg_c6_mem_we", mem_we, 0);
    cyc(); prog_mode = 0; p_req = 1;
    @(negedge clk); chk("pg_c7_p_rvalid", p_rvalid, 1); chk("pg_c7_p_rdata", p_rdata, 32'hDEAD_BEEF);
    chk("pg_c7_p_gnt", p_gnt, 0); chk("pg_c7_hold", cpu_hold, 1);
    cyc(); p_req = 0; d_req = 1; d_we = 0; d_addr = 9;
    @(negedge clk); chk("pg_c8_hold", cpu_hold, 1); chk("pg_c8_gnts", {if_gnt, d_gnt}, 0);
    cyc();
    @(negedge clk); chk("pg_c9_hold", cpu_hold, 0); chk("pg_c9_if_gnt", if_gnt, 1); chk("pg_c9_d_gnt", d_gnt, 0);
    cyc(); if_addr = 22;
    @(negedge clk); chk("pg_c10_d_gnt", d_gnt, 1); chk("pg_c10_if_gnt", if_gnt, 0);
    cyc(); d_req = 0;
    @(negedge clk); chk("pg_c11_if_gnt", if_gnt, 1);
    idle(3);

    // Random CPU traffic; the scoreboard checks data and latency, here the wait bound.
    ig = 0; dg = 0; iw = 0; dw = 0;
    for (int c = 0; c < 400; c++) begin
      cyc();
      if (ig) if_req = 0;
      if (dg) d_req = 0;
      if (!if_req && $urandom_range(0, 3) != 0) begin
        if_req = 1; if_addr = AW'($urandom);
      end
      if (!d_req && $urandom_range(0, 3) != 0) begin
        d_req = 1; d_we = 1'($urandom); d_be = NB'($urandom);
        d_addr = AW'($urandom); d_wdata = $urandom;
      end
      @(negedge clk);
      ig = if_gnt; dg = d_gnt;
      iw = (if_req && !if_gnt) ? iw + 1 : 0;
      dw = (d_req && !d_gnt) ? dw + 1 : 0;
      chk("rand_if_wait", iw <= 1, 1);
      chk("rand_d_wait", dw <= 1, 1);
    end
    idle(4);

    // Reset with two reads in flight: everything drops at once and nothing returns.
    cyc(); if_req = 1; if_addr = 4; d_we = 0;
    @(negedge clk); chk("mr_if_gnt", if_gnt, 1);
    cyc(); if_req = 0; d_req = 1; d_addr = 5;
    @(negedge clk); chk("mr_d_gnt", d_gnt, 1);
    cyc(); d_req = 0; if_req = 1; rst_n = 0;
    #1;
    chk("mr_if_rvalid", if_rvalid, 0); chk("mr_if_gnt0", if_gnt, 0);
    chk("mr_mem_en", mem_en, 0); chk("mr_hold", cpu_hold, 0);
    cyc(); if_req = 0;
    cyc(); rst_n = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("mr_post_rvalid", {if_rvalid, d_rvalid, p_rvalid}, 0);
      chk("mr_post_hold", cpu_hold, 0);
      cyc();
    end
    if_req = 1; if_addr = 7;
    @(negedge clk); chk("mr_post_if_gnt", if_gnt, 1);
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port program/data SRAM between three requesters: CPU instruction fetch (IF), CPU load/store (DATA), and the JTAG programming controller (PROG).
- In normal operation, IF and DATA are arbitrated round-robin. When programming mode is entered, the CPU ports are drained and PROG gets exclusive ownership.
- The memory port is fully pipelined: one accepted request per cycle, with read data returned to the originating requester, tagged.

Parameters:
- ADDR_WIDTH, 6, word-address width of the memory.
- DATA_WIDTH, 32, data width; must be a multiple of 8. NBYTES = DATA_WIDTH/8.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- prog_mode  in  1  programming-mode request (clk domain, already synchronised)
- if_req  in  1  fetch request
- if_addr  in  ADDR_WIDTH  fetch address
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  fetch data valid
- if_rdata  out  DATA_WIDTH  fetch data
- d_req  in  1  data request
- d_we  in  1  data write
- d_be  in  NBYTES  byte enables (writes only)
- d_addr  in  ADDR_WIDTH  data address
- d_wdata  in  DATA_WIDTH  write data
- d_gnt  out  1  data request accepted
- d_rvalid  out  1  read data valid
- d_rdata  out  DATA_WIDTH  read data
- p_req  in  1  programming request
- p_we  in  1  programming write (full word)
- p_addr  in  ADDR_WIDTH  programming address
- p_wdata  in  DATA_WIDTH  programming write data
- p_gnt  out  1  programming request accepted
- p_rvalid  out  1  programming read data valid
- p_rdata  out  DATA_WIDTH  programming read data
- mem_en  out  1  memory access strobe
- mem_we  out  NBYTES  byte write strobes
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_rdata  in  DATA_WIDTH  memory read data, valid 1 cycle after mem_en
- cpu_hold  out  1  CPU must stall and not issue requests

Behaviour:
- Reset (async, rst_n=0): state=NORMAL; all gnt, rvalid and mem_en outputs 0; mem_we=0; mem_addr/mem_wdata=0; round-robin pointer favours IF; tag pipeline empty; cpu_hold=0.
- Handshake: a requester holds req and its fields stable until it sees gnt. gnt is combinational in the acceptance cycle N. At most one gnt per cycle.
- Pipeline timing: the accepted request is registered onto the mem_* outputs in N+1. mem_rdata is captured and rvalid is pulsed to the originator in N+2. Read latency is therefore 2 cycles after gnt, and throughput is 1 access per cycle.
- Tag pipeline: a 2-stage {valid, id} pipeline follows each read. Writes produce no rvalid. The rdata outputs are the mem_rdata register, and are meaningful only while the matching rvalid is high.
- IF reads: mem_we=0.
- DATA writes: mem_we=d_be. A write with d_be=0 is granted, but mem_en stays 0 and no rvalid is produced.
- PROG writes: mem_we all ones.
- State NORMAL: arbitrate IF and DATA. With a single requester, grant it. If both request, grant the one not granted last; the pointer updates only on a grant, so the worst-case wait is 1 cycle. p_req is ignored, p_gnt=0.
- NORMAL -> DRAIN when prog_mode=1. No CPU gnt is issued in the cycle prog_mode is seen high.
- State DRAIN: no grants; cpu_hold=1. Go to PROG when the tag pipeline and mem stage are empty. Worst case is 2 cycles.
- State PROG: cpu_hold=1; only p_req is granted (every cycle it is high).
- PROG -> RELEASE when prog_mode=0. No grant is issued in that cycle.
- State RELEASE: no grants; cpu_hold=1; wait until the pipeline is empty, then go to NORMAL. The round-robin pointer resets to favour IF.
- If prog_mode drops during DRAIN: finish draining, then go to RELEASE and on to NORMAL. PROG is never entered.
- cpu_hold = (state != NORMAL) || (state==NORMAL && prog_mode). It is combinational, so the CPU sees the hold in the same cycle its grants stop.
- Mid-operation reset: in-flight reads are discarded silently and no rvalid is emitted after reset.

Decomposition:
- Package mem_arb_pkg:
  - requester id enum: REQ_IF=2'd0, REQ_D=2'd1, REQ_P=2'd2.
  - arbiter state enum: NORMAL, DRAIN, PROG, RELEASE (2 bits).
- Sub-module mem_arb_rr2: 2-requester round-robin grant with pointer update on grant, async reset, and a sync clear input used on RELEASE->NORMAL.

Test Plan:
- Back-to-back IF reads at addr 0,1,2 (memory model word = addr*3): if_gnt high 3 consecutive cycles; if_rvalid high 2 cycles after each gnt; data 0,3,6.
- IF and DATA both requesting continuously for 6 cycles: grants alternate IF,D,IF,D,IF,D. Stop IF: DATA is then granted every cycle.
- DATA write addr 5, data 0xAABBCCDD, be=4'b0011, then read addr 5 (prior content 0x11223344): mem_we=0011 on the write; read returns 0x1122CCDD; d_rvalid only on the read. A write with be=0 produces no mem_en.
- IF read granted, then prog_mode asserted next cycle with if_req still high: that read still returns; no further if_gnt; cpu_hold=1; PROG entered only after the pipeline is empty. p_req write addr 3=0xDEADBEEF gets p_gnt, mem_we=1111.
- In PROG, p read addr 3 -> p_rvalid with 0xDEADBEEF 2 cycles after p_gnt. Drop prog_mode -> RELEASE -> NORMAL, cpu_hold falls; simultaneous IF/DATA request grants IF first.
- rst_n pulsed low while 2 reads are in flight: all rvalid and gnt outputs go to 0 immediately; no rvalid appears after release; state is NORMAL.
